// File: rtl/datapath_unit.sv
// Execution datapath of the 16-bit CPU: register file, data memory, write-back mux and ALU.
// Optional status flags are built when DP_FLAGS_EN is defined; otherwise Flags is tied to zero.
module datapath_unit (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [7:0]  D_Addr,
  input  logic        D_Wr,
  input  logic        RF_s,
  input  logic        RF_W_en,
  input  logic [3:0]  RF_Ra_Addr,
  input  logic [3:0]  RF_Rb_Addr,
  input  logic [3:0]  RF_W_Addr,
  input  logic [2:0]  ALU_s0,
  output logic [15:0] ALU_A,
  output logic [15:0] ALU_B,
  output logic [15:0] ALU_Out,
  output logic [15:0] Mem_Q,
  output logic [2:0]  Flags
);
  localparam int DATA_W = 16;

  logic [DATA_W-1:0] rf_q [16];
  logic [DATA_W-1:0] rf_d [16];
  logic [DATA_W-1:0] mem_q [256];
  logic [DATA_W-1:0] mem_rd_q, mem_rd_d;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W:0]   alu_ext;
  logic              alu_carry;

  assign ALU_A = rf_q[RF_Ra_Addr];
  assign ALU_B = rf_q[RF_Rb_Addr];

  // Bit 16 of the widened result is carry-out for adds and borrow (A<B) for subtract.
  always_comb begin
    alu_ext = '0;
    case (ALU_s0)
      3'b000:  alu_ext = '0;
      3'b001:  alu_ext = {1'b0, ALU_A} + {1'b0, ALU_B};
      3'b010:  alu_ext = {1'b0, ALU_A} - {1'b0, ALU_B};
      3'b011:  alu_ext = {1'b0, ALU_A};
      3'b100:  alu_ext = {1'b0, ALU_A ^ ALU_B};
      3'b101:  alu_ext = {1'b0, ALU_A | ALU_B};
      3'b110:  alu_ext = {1'b0, ALU_A & ALU_B};
      default: alu_ext = {1'b0, ALU_A} + 17'd1;
    endcase
  end

  assign ALU_Out   = alu_ext[DATA_W-1:0];
  assign alu_carry = alu_ext[DATA_W];
  assign wb_data   = RF_s ? mem_rd_q : ALU_Out;
  assign Mem_Q     = mem_rd_q;

  always_comb begin
    rf_d = rf_q;
    if (RF_W_en) rf_d[RF_W_Addr] = wb_data;
    mem_rd_d = mem_q[D_Addr];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
      mem_rd_q <= '0;
    end else begin
      rf_q     <= rf_d;
      mem_rd_q <= mem_rd_d;
    end
  end

  // Memory array is never cleared; only the write is blocked during reset.
  always_ff @(posedge Clk) begin
    if (!Rst && D_Wr) mem_q[D_Addr] <= ALU_A;
  end

`ifdef DP_FLAGS_EN
  logic [2:0] flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (RF_W_en && !RF_s) flags_d = {ALU_Out[DATA_W-1], alu_carry, (ALU_Out == '0)};
  end

  always_ff @(posedge Clk) begin
    if (Rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  assign Flags = flags_q;
`else
  logic unused_carry;
  assign unused_carry = alu_carry;
  assign Flags = 3'b000;
`endif

endmodule

// File: tb/tb_datapath_unit.sv
// Directed-vector bench for datapath_unit: stimulus queues expected values tagged with the
// cycle they apply to; a negedge monitor pops and compares them against the DUT outputs.
module tb_datapath_unit;
  logic        Clk = 1'b0;
  logic        Rst;
  logic [7:0]  D_Addr;
  logic        D_Wr, RF_s, RF_W_en;
  logic [3:0]  RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr;
  logic [2:0]  ALU_s0;
  logic [15:0] ALU_A, ALU_B, ALU_Out, Mem_Q;
  logic [2:0]  Flags;

  datapath_unit dut (
    .Clk(Clk), .Rst(Rst), .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s), .RF_W_en(RF_W_en),
    .RF_Ra_Addr(RF_Ra_Addr), .RF_Rb_Addr(RF_Rb_Addr), .RF_W_Addr(RF_W_Addr), .ALU_s0(ALU_s0),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_Out(ALU_Out), .Mem_Q(Mem_Q), .Flags(Flags)
  );

  always #5 Clk = ~Clk;

  typedef enum logic [2:0] {K_A, K_B, K_OUT, K_MEMQ, K_FLAGS} kind_t;
  typedef struct {
    int          cyc;
    kind_t       kind;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  logic done = 1'b0;

`ifdef DP_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: compares every expectation scheduled for the current cycle.
  always @(negedge Clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [15:0] act;
      e = q.pop_front();
      case (e.kind)
        K_A:     act = ALU_A;
        K_B:     act = ALU_B;
        K_OUT:   act = ALU_Out;
        K_MEMQ:  act = Mem_Q;
        default: act = {13'd0, Flags};
      endcase
      tests++;
      if (e.cyc != cyc) begin
        fails++;
        $display("FAIL %s: check for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
      end else if (act !== e.exp) begin
        fails++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_val(input kind_t k, input logic [15:0] v, input string nm);
    exp_t e;
    e.cyc = cyc; e.kind = k; e.exp = v; e.name = nm;
    q.push_back(e);
  endtask

  task automatic idle();
    Rst = 1'b0; D_Addr = '0; D_Wr = 1'b0; RF_s = 1'b0; RF_W_en = 1'b0;
    RF_Ra_Addr = '0; RF_Rb_Addr = '0; RF_W_Addr = '0; ALU_s0 = 3'b000;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    idle();
  endtask

  task automatic check_reg(input logic [3:0] r, input logic [15:0] v, input string nm);
    RF_Ra_Addr = r;
    ALU_s0 = 3'b011;
    expect_val(K_A, v, nm);
    expect_val(K_OUT, v, {nm, "_out"});
    step();
  endtask

  task automatic load(input logic [7:0] a, input logic [3:0] rd, input logic [15:0] v,
                      input bit rst_in_wb);
    D_Addr = a;
    step();
    D_Addr = a; RF_s = 1'b1; RF_W_en = 1'b1; RF_W_Addr = rd; Rst = rst_in_wb;
    expect_val(K_MEMQ, v, "load_memq");
    step();
  endtask

  task automatic alu_op(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [15:0] v, input string nm);
    ALU_s0 = op; RF_Ra_Addr = ra; RF_Rb_Addr = rb;
    expect_val(K_OUT, v, nm);
    step();
  endtask

  initial begin
    dut.mem_q[8'h1B] = 16'h1234;
    dut.mem_q[8'h1C] = 16'h0F0F;
    dut.mem_q[8'h1D] = 16'hFFFF;
    dut.mem_q[8'h1E] = 16'h0001;
    idle();
    Rst = 1'b1;
    step();

    // Reset state
    expect_val(K_MEMQ, 16'h0000, "rst_memq");
    expect_val(K_FLAGS, 16'h0000, "rst_flags");
    for (int r = 0; r < 16; r++) begin
      RF_Ra_Addr = 4'(r);
      RF_Rb_Addr = 4'(15 - r);
      expect_val(K_A, 16'h0000, $sformatf("rst_r%0d", r));
      expect_val(K_B, 16'h0000, $sformatf("rst_rb%0d", 15 - r));
      step();
    end

    // LOADs
    load(8'h1B, 4'd5, 16'h1234, 1'b0);
    check_reg(4'd5, 16'h1234, "load_r5");
    load(8'h1C, 4'd6, 16'h0F0F, 1'b0);
    check_reg(4'd6, 16'h0F0F, "load_r6");

    // ALU operations without write-back
    alu_op(3'b000, 4'd5, 4'd6, 16'h0000, "alu_zero");
    alu_op(3'b011, 4'd5, 4'd6, 16'h1234, "alu_pass");
    alu_op(3'b100, 4'd5, 4'd6, 16'h1D3B, "alu_xor");
    alu_op(3'b101, 4'd5, 4'd6, 16'h1F3F, "alu_or");
    alu_op(3'b110, 4'd5, 4'd6, 16'h0204, "alu_and");
    alu_op(3'b111, 4'd5, 4'd6, 16'h1235, "alu_inc");

    // ADD R5+R6 -> R7
    RF_Ra_Addr = 4'd5; RF_Rb_Addr = 4'd6; ALU_s0 = 3'b001; RF_W_en = 1'b1; RF_W_Addr = 4'd7;
    expect_val(K_OUT, 16'h2143, "add_out");
    step();
    expect_val(K_FLAGS, FLAGS_ON ? 16'h0000 : 16'h0000, "add_flags");
    check_reg(4'd7, 16'h2143, "add_r7");

    // SUB R6-R5 -> R8
    RF_Ra_Addr = 4'd6; RF_Rb_Addr = 4'd5; ALU_s0 = 3'b010; RF_W_en = 1'b1; RF_W_Addr = 4'd8;
    expect_val(K_OUT, 16'hFCDB, "sub_out");
    step();
    expect_val(K_FLAGS, FLAGS_ON ? 16'h0006 : 16'h0000, "sub_flags");
    check_reg(4'd8, 16'hFCDB, "sub_r8");

    // STORE R7 -> 0x80, then read back
    RF_Ra_Addr = 4'd7; D_Addr = 8'h80; D_Wr = 1'b1;
    step();
    D_Addr = 8'h80;
    step();
    expect_val(K_MEMQ, 16'h2143, "store_read");
    // Same-cycle write and read at 0x80: old word first, new word next
    RF_Ra_Addr = 4'd8; D_Addr = 8'h80; D_Wr = 1'b1;
    step();
    expect_val(K_MEMQ, 16'h2143, "rdw_old");
    D_Addr = 8'h80;
    step();
    expect_val(K_MEMQ, 16'hFCDB, "rdw_new");
    step();

    // LOAD does not disturb flags; ADD 0xFFFF+0x0001 wraps to zero
    load(8'h1D, 4'd9, 16'hFFFF, 1'b0);
    load(8'h1E, 4'd10, 16'h0001, 1'b0);
    expect_val(K_FLAGS, FLAGS_ON ? 16'h0006 : 16'h0000, "load_keeps_flags");
    RF_Ra_Addr = 4'd9; RF_Rb_Addr = 4'd10; ALU_s0 = 3'b001; RF_W_en = 1'b1; RF_W_Addr = 4'd11;
    expect_val(K_OUT, 16'h0000, "wrap_out");
    step();
    expect_val(K_FLAGS, FLAGS_ON ? 16'h0003 : 16'h0000, "wrap_flags");
    check_reg(4'd11, 16'h0000, "wrap_r11");

    // Write to the register being read: old value until the edge
    RF_Ra_Addr = 4'd5; ALU_s0 = 3'b111; RF_W_en = 1'b1; RF_W_Addr = 4'd5;
    expect_val(K_A, 16'h1234, "wr_same_old");
    step();
    check_reg(4'd5, 16'h1235, "wr_same_new");

    // Reset asserted in the LOAD write-back cycle
    load(8'h1B, 4'd3, 16'h1234, 1'b1);
    expect_val(K_FLAGS, 16'h0000, "midrst_flags");
    expect_val(K_MEMQ, 16'h0000, "midrst_memq");
    check_reg(4'd3, 16'h0000, "midrst_r3");
    check_reg(4'd5, 16'h0000, "midrst_r5");
    D_Addr = 8'h1B;
    step();
    expect_val(K_MEMQ, 16'h1234, "midrst_mem_kept");
    D_Addr = 8'h80;
    step();
    expect_val(K_MEMQ, 16'hFCDB, "midrst_mem80_kept");
    step();
    step();

    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: %0d checks left, expected 0", q.size());
    end
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
    end
  end

endmodule
